d_flip_flop: RTL and testbench



---
 rtl/lifo_pkg.sv | 19 +
 rtl/d_flip_flop_cell.sv | 27 ++
 rtl/d_flip_flop.sv | 49 ++++
 tb/tb_d_flip_flop.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/lifo_pkg.sv
`timescale 100ns/10ns
// Shared constants for the SSBR/LIFO storage levels: default word width,
// default reset value and a legal-width helper used by the registers.
package lifo_pkg;

   localparam int unsigned LIFO_MAX_W  = 64;
   localparam int unsigned LIFO_DATA_W = 1;

   // Reset values are carried at the maximum width; each register keeps
   // only the low WIDTH bits.
   typedef logic [LIFO_MAX_W-1:0] lifo_word_t;

   localparam lifo_word_t LIFO_RST_VAL = '0;

   function automatic bit lifo_width_ok(input int w);
      return (w >= 1) && (w <= int'(LIFO_MAX_W));
   endfunction

endpackage

// File: rtl/d_flip_flop_cell.sv
`timescale 100ns/10ns
// Single-bit storage cell: rising-edge capture with synchronous reset
// taking priority over the clock enable.
module dff_cell #(
   parameter logic RST_BIT = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic d,
   output logic q
);

   logic r_q;

   // rst wins over en; with en low the bit simply holds
   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= RST_BIT;
      end else if (en) begin
         r_q <= d;
      end
   end

   assign q = r_q;

endmodule

// File: rtl/d_flip_flop.sv
`timescale 100ns/10ns
// WIDTH-bit D register built from independent dff_cell bits, with a
// combinational inverted output derived only from the stored value.
module d_flip_flop
   import lifo_pkg::*;
#(
   parameter int         WIDTH       = LIFO_DATA_W,
   parameter lifo_word_t RESET_VALUE = LIFO_RST_VAL
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qn
);

   logic [WIDTH-1:0] w_q;

   // Reject unsupported widths when the design is elaborated
   if (!lifo_width_ok(WIDTH)) begin : g_bad_width
      $fatal(1, "d_flip_flop: WIDTH=%0d outside 1..%0d", WIDTH, LIFO_MAX_W);
   end

   // Reset value bits above WIDTH are dropped; flag it so it is not silent
   if (WIDTH < int'(LIFO_MAX_W)) begin : g_rv_chk
      if ((RESET_VALUE >> WIDTH) != '0) begin : g_rv_trunc
         $warning("d_flip_flop: RESET_VALUE 'h%0h truncated to %0d bits",
                  RESET_VALUE, WIDTH);
      end
   end

   // One cell per bit; bits never interact
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      dff_cell #(
         .RST_BIT (RESET_VALUE[i])
      ) u_cell (
         .clk (clk),
         .rst (rst),
         .en  (en),
         .d   (D[i]),
         .q   (w_q[i])
      );
   end

   assign Q  = w_q;
   assign Qn = ~w_q;

endmodule

// File: tb/tb_d_flip_flop.sv
`timescale 100ns/10ns
module tb_d_flip_flop;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       d0, d1;
   logic [7:0] d8;
   logic       q0, qn0, q1, qn1;
   logic [7:0] q8, qn8;

   int checks = 0;
   int errors = 0;

   always #0.5 clk = ~clk;

   d_flip_flop #(.WIDTH(1)) u_dut0 (
      .clk(clk), .rst(rst), .en(en), .D(d0), .Q(q0), .Qn(qn0)
   );

   d_flip_flop #(.WIDTH(1), .RESET_VALUE(64'h1)) u_dut1 (
      .clk(clk), .rst(rst), .en(en), .D(d1), .Q(q1), .Qn(qn1)
   );

   d_flip_flop #(.WIDTH(8), .RESET_VALUE(64'hA5)) u_dut8 (
      .clk(clk), .rst(rst), .en(en), .D(d8), .Q(q8), .Qn(qn8)
   );

   // one rising edge, then return to the falling edge to sample and drive
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; d0 = 1'b1; d1 = 1'b0; d8 = 8'hFF;
      tick();
      checks++; if (q0 !== 1'b0) begin errors++; $display("FAIL reset_q0 got %b exp 0", q0); end
      checks++; if (qn0 !== 1'b1) begin errors++; $display("FAIL reset_qn0 got %b exp 1", qn0); end
      checks++; if (q1 !== 1'b1) begin errors++; $display("FAIL reset_q1 got %b exp 1", q1); end
      checks++; if (q8 !== 8'hA5) begin errors++; $display("FAIL reset_q8 got %h exp a5", q8); end
      checks++; if (qn8 !== 8'h5A) begin errors++; $display("FAIL reset_qn8 got %h exp 5a", qn8); end
   endtask

   task automatic test_capture();
      rst = 1'b0; en = 1'b1; d0 = 1'b0;
      tick();
      checks++; if (q0 !== 1'b0) begin errors++; $display("FAIL capture0_q got %b exp 0", q0); end
      checks++; if (qn0 !== 1'b1) begin errors++; $display("FAIL capture0_qn got %b exp 1", qn0); end
      d0 = 1'b1;
      #0.2;
      checks++; if (q0 !== 1'b0) begin errors++; $display("FAIL capture_latency got %b exp 0", q0); end
      tick();
      checks++; if (q0 !== 1'b1) begin errors++; $display("FAIL capture1_q got %b exp 1", q0); end
      checks++; if (qn0 !== 1'b0) begin errors++; $display("FAIL capture1_qn got %b exp 0", qn0); end
   endtask

   task automatic test_sync_reset();
      rst = 1'b1;
      #0.2;
      checks++; if (q0 !== 1'b1) begin errors++; $display("FAIL sreset_before_edge got %b exp 1", q0); end
      tick();
      checks++; if (q0 !== 1'b0) begin errors++; $display("FAIL sreset_at_edge got %b exp 0", q0); end
      d0 = 1'b1;
      tick();
      checks++; if (q0 !== 1'b0) begin errors++; $display("FAIL sreset_held got %b exp 0", q0); end
      rst = 1'b0;
      tick();
      checks++; if (q0 !== 1'b1) begin errors++; $display("FAIL sreset_release got %b exp 1", q0); end
   endtask

   task automatic test_enable_hold();
      rst = 1'b0; en = 1'b1; d0 = 1'b1;
      tick();
      checks++; if (q0 !== 1'b1) begin errors++; $display("FAIL hold_load got %b exp 1", q0); end
      en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         d0 = ~d0;
         tick();
         checks++; if (q0 !== 1'b1) begin errors++; $display("FAIL hold_cycle%0d got %b exp 1", i, q0); end
      end
      en = 1'b1; d0 = 1'b0;
      tick();
      checks++; if (q0 !== 1'b0) begin errors++; $display("FAIL hold_reenable got %b exp 0", q0); end
   endtask

   task automatic test_reset_priority();
      rst = 1'b0; en = 1'b1; d0 = 1'b1; d1 = 1'b0;
      tick();
      checks++; if (q0 !== 1'b1) begin errors++; $display("FAIL prio_pre_q0 got %b exp 1", q0); end
      checks++; if (q1 !== 1'b0) begin errors++; $display("FAIL prio_pre_q1 got %b exp 0", q1); end
      rst = 1'b1; en = 1'b1; d0 = 1'b1; d1 = 1'b1;
      tick();
      checks++; if (q0 !== 1'b0) begin errors++; $display("FAIL prio_rv0 got %b exp 0", q0); end
      checks++; if (q1 !== 1'b1) begin errors++; $display("FAIL prio_rv1 got %b exp 1", q1); end
      // enable low must not block reset either
      rst = 1'b0; en = 1'b1; d1 = 1'b0;
      tick();
      rst = 1'b1; en = 1'b0;
      tick();
      checks++; if (q1 !== 1'b1) begin errors++; $display("FAIL prio_rv1_en0 got %b exp 1", q1); end
      rst = 1'b0; en = 1'b1;
   endtask

   task automatic test_wide();
      rst = 1'b1; en = 1'b1; d8 = 8'h00;
      tick();
      checks++; if (q8 !== 8'hA5) begin errors++; $display("FAIL wide_reset_q got %h exp a5", q8); end
      checks++; if (qn8 !== 8'h5A) begin errors++; $display("FAIL wide_reset_qn got %h exp 5a", qn8); end
      rst = 1'b0; d8 = 8'h3C;
      tick();
      checks++; if (q8 !== 8'h3C) begin errors++; $display("FAIL wide_3c_q got %h exp 3c", q8); end
      checks++; if (qn8 !== 8'hC3) begin errors++; $display("FAIL wide_3c_qn got %h exp c3", qn8); end
      d8 = 8'hFF;
      #0.2;
      checks++; if (q8 !== 8'h3C) begin errors++; $display("FAIL wide_latency got %h exp 3c", q8); end
      tick();
      checks++; if (q8 !== 8'hFF) begin errors++; $display("FAIL wide_ff_q got %h exp ff", q8); end
      d8 = 8'h00;
      tick();
      checks++; if (q8 !== 8'h00) begin errors++; $display("FAIL wide_00_q got %h exp 00", q8); end
      checks++; if (qn8 !== 8'hFF) begin errors++; $display("FAIL wide_00_qn got %h exp ff", qn8); end
      en = 1'b0; d8 = 8'h96;
      tick();
      checks++; if (q8 !== 8'h00) begin errors++; $display("FAIL wide_hold got %h exp 00", q8); end
      en = 1'b1;
      tick();
      checks++; if (q8 !== 8'h96) begin errors++; $display("FAIL wide_96_q got %h exp 96", q8); end
   endtask

   task automatic test_glitch();
      rst = 1'b0; en = 1'b1; d0 = 1'b0;
      tick();
      checks++; if (q0 !== 1'b0) begin errors++; $display("FAIL glitch_pre got %b exp 0", q0); end
      #0.1 d0 = 1'b1;
      #0.1 d0 = 1'b0;
      tick();
      checks++; if (q0 !== 1'b0) begin errors++; $display("FAIL glitch_low got %b exp 0", q0); end
      d0 = 1'b1;
      tick();
      #0.1 d0 = 1'b0;
      #0.1 d0 = 1'b1;
      tick();
      checks++; if (q0 !== 1'b1) begin errors++; $display("FAIL glitch_high got %b exp 1", q0); end
   endtask

   initial begin
      #2000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0; en = 1'b0; d0 = 1'b0; d1 = 1'b0; d8 = 8'h00;
      @(negedge clk);
      test_reset();
      test_capture();
      test_sync_reset();
      test_enable_hold();
      test_reset_priority();
      test_wide();
      test_glitch();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
